// File: rtl/mem_read_pkg.sv
// Shared types and constants for the memory read controller.
package mem_read_pkg;

    localparam int ADDR_W = 16;
    localparam int BYTE_W = 8;
    localparam int DATA_W = 2 * BYTE_W;

    localparam logic [DATA_W-1:0] ERR_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_read_timer.sv
// Per-byte MEM_ACK wait counter; flags expiry on the cycle the wait limit is reached.
module mem_read_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic req,
    input  logic ack,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (req && !ack) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ACK in the limit cycle takes priority, so expiry requires !ack.
    assign expired = req && !ack && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_read_ctrl.sv
// Byte / little-endian word reader over an 8-bit REQ/ACK memory bus.
// Optional MEM_ACK timeout abort is enabled by defining MEM_READ_TIMEOUT_EN.
module mem_read_ctrl
    import mem_read_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic              WORD,
    input  logic [ADDR_W-1:0] ADDR,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] DATA,
    output logic              ERR,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [BYTE_W-1:0] MEM_RDATA
);

    state_e            state_q, state_d;
    logic              word_q, word_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              timeout;

`ifdef MEM_READ_TIMEOUT_EN
    logic timer_clr;

    // Every state change either starts a fresh byte request or ends the read.
    assign timer_clr = (state_d != state_q);

    mem_read_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .clr    (timer_clr),
        .req    (req_q),
        .ack    (MEM_ACK),
        .expired(timeout)
    );
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT_CYCLES > 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        err_d   = err_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    addr_d  = ADDR;
                    word_d  = WORD;
                    req_d   = 1'b1;
                    err_d   = 1'b0;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                if (MEM_ACK) begin
                    data_d[BYTE_W-1:0] = MEM_RDATA;
                    if (word_q) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = RD_HI;
                    end else begin
                        data_d[DATA_W-1:BYTE_W] = '0;
                        req_d   = 1'b0;
                        state_d = FIN;
                    end
                end else if (timeout) begin
                    data_d  = ERR_DATA;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = FIN;
                end
            end
            RD_HI: begin
                if (MEM_ACK) begin
                    data_d[DATA_W-1:BYTE_W] = MEM_RDATA;
                    req_d   = 1'b0;
                    state_d = FIN;
                end else if (timeout) begin
                    data_d  = ERR_DATA;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered, so derive them from the next state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            word_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign DATA     = data_q;
    assign ERR      = err_q;
    assign MEM_REQ  = req_q;
    assign MEM_ADDR = addr_q;

endmodule

// File: doc/mem_read_ctrl.md
Name: mem_read_ctrl

Overview:
- Consumes the 16-bit address produced by the memory-read address bus mux.
- Runs a byte or little-endian word read on the 8-bit memory bus using a REQ/ACK handshake.
- Returns the assembled data to the datapath with a one-cycle DONE strobe.
- Sits between the address bus and the memory interface; one read in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles for MEM_ACK per byte access. Used only with the optional feature.
- ADDR_W, 16: address width. Must match the address bus output.

Ports:
- CLK  input  1  single clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  request a read; sampled only in IDLE.
- WORD  input  1  1 = 16-bit read (two bytes), 0 = byte read; captured with START.
- ADDR  input  16  read address from the address bus mux; captured with START.
- BUSY  output  1  high whenever state is not IDLE.
- DONE  output  1  one-cycle strobe: DATA (and ERR) are valid.
- DATA  output  16  read result; holds until the next DONE.
- ERR  output  1  valid with DONE; timeout abort flag.
- MEM_REQ  output  1  memory request.
- MEM_ADDR  output  16  memory byte address; stable while MEM_REQ is high.
- MEM_ACK  input  1  memory acknowledge; MEM_RDATA is valid in the same cycle.
- MEM_RDATA  input  8  memory read byte.

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE.
  - MEM_REQ=0, MEM_ADDR=0, DATA=0, DONE=0, ERR=0, BUSY=0.
  - All outputs are registered; reset forces them immediately, mid-transaction included. The pending read is discarded with no DONE.
- States: IDLE, RD_LO, RD_HI, FIN.
- IDLE:
  - On START=1: latch ADDR into MEM_ADDR, latch WORD, set MEM_REQ=1, go to RD_LO.
  - START while not IDLE is ignored (no queueing).
- RD_LO:
  - MEM_REQ and MEM_ADDR are held until MEM_ACK=1 is sampled.
  - On ACK: capture MEM_RDATA into DATA[7:0].
  - If word: MEM_ADDR <= MEM_ADDR+1 (mod 2^16, so 0xFFFF wraps to 0x0000), MEM_REQ stays 1, go to RD_HI.
  - If byte: DATA[15:8]<=0, MEM_REQ<=0, go to FIN.
- RD_HI:
  - On ACK: capture MEM_RDATA into DATA[15:8], MEM_REQ<=0, go to FIN.
- FIN:
  - DONE=1 for exactly this cycle, then return to IDLE.
  - BUSY is high in FIN, so a START in the FIN cycle is ignored.
- Latency with immediate ACK:
  - Byte: START at cycle 0, DONE at cycle 2.
  - Word: START at cycle 0, DONE at cycle 3.
  - Each wait cycle on ACK adds one cycle.
- MEM_ACK outside RD_LO/RD_HI is ignored.
- DATA updates only as bytes are captured. The byte read clears DATA[15:8] on capture. DATA is otherwise stable between reads.

Optional Feature:
- MEM_READ_TIMEOUT_EN defined:
  - A wait counter clears on each new byte request and increments each cycle MEM_REQ=1 && MEM_ACK=0.
  - When the counter reaches TIMEOUT_CYCLES: MEM_REQ<=0, DATA<=16'hFFFF, ERR<=1, go to FIN.
  - ERR clears to 0 on the next START accepted.
  - An ACK arriving in the same cycle as the limit wins: normal capture, no error.
- MEM_READ_TIMEOUT_EN undefined:
  - No counter; the controller waits indefinitely.
  - ERR is a constant 0.

Decomposition:
- Package mem_read_pkg:
  - state enum {IDLE, RD_LO, RD_HI, FIN}.
  - ADDR_W=16, BYTE_W=8.
  - ERR_DATA=16'hFFFF.
- Sub-module: mem_read_timer (wait counter plus limit compare), instantiated only under MEM_READ_TIMEOUT_EN. The FSM stays in mem_read_ctrl.

Test Plan:
1. Byte read, zero-wait:
   - Stimulus: ADDR=0x1234, WORD=0, START pulse; memory ACKs immediately with 0xA5.
   - Response: MEM_ADDR=0x1234 for 1 cycle; DONE 2 cycles after START; DATA=0x00A5; ERR=0.
2. Word read with waits:
   - Stimulus: ADDR=0x2000, WORD=1; low byte 0x34 ACKed after 3 waits, high byte 0x12 after 1 wait.
   - Response: MEM_ADDR sequence 0x2000 then 0x2001; MEM_REQ continuously high; DATA=0x1234; DONE at cycle 7.
3. Wrap-around:
   - Stimulus: ADDR=0xFFFF, WORD=1.
   - Response: second access at MEM_ADDR=0x0000; DATA={byte@0x0000, byte@0xFFFF}.
4. START while BUSY, and START in the FIN cycle:
   - Response: both ignored; exactly one DONE; MEM_ADDR unchanged.
5. Reset mid-operation:
   - Stimulus: RESET_N low while in RD_HI, asserted asynchronously between clock edges.
   - Response: MEM_REQ=0 and BUSY=0 without waiting for a clock edge; no DONE; a new read after reset works.
6. (MEM_READ_TIMEOUT_EN, TIMEOUT_CYCLES=4) No ACK:
   - Response: MEM_REQ high 4 cycles then low; DONE with ERR=1, DATA=0xFFFF.
   - ACK on the 4th wait cycle gives normal data with ERR=0.
